// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding, page descriptor and address-width helper for the capture sequencer
package capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_STALL = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam int LEN_W = 16;

    typedef struct packed {
        logic             bank;
        logic [LEN_W-1:0] len;
    } page_desc_t;

    function automatic int page_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_page_sequencer_tracker.sv
// rtl/capture_page_sequencer_tracker.sv - two-bank pending-page tracker, offers the oldest pending page first
module page_bank_tracker
    import capture_pkg::*;
#(
    parameter int PAGE_AW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mark_valid,
    input  page_desc_t       mark_desc,
    input  logic             page_ack,
    output logic             page_ready,
    output logic             page_bank,
    output logic [PAGE_AW:0] page_len,
    output logic [1:0]       pending_after_ack
);

    logic [1:0]       pending;
    logic [PAGE_AW:0] len_q [2];
    logic             older;
    logic             sel;
    logic [1:0]       mark_vec;
    logic             unused_desc;

    assign unused_desc = ^mark_desc.len[LEN_W-1:PAGE_AW+1];

    // The ack is applied before a new mark so a bank can be freed and re-filled on one edge.
    always_comb begin
        sel               = (&pending) ? older : pending[1];
        pending_after_ack = pending;
        if (page_ack && (|pending)) begin
            pending_after_ack[sel] = 1'b0;
        end
        mark_vec = '0;
        if (mark_valid) begin
            mark_vec[mark_desc.bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            older    <= 1'b0;
            len_q[0] <= '0;
            len_q[1] <= '0;
        end else begin
            pending <= pending_after_ack | mark_vec;
            if (mark_valid) begin
                len_q[mark_desc.bank] <= mark_desc.len[PAGE_AW:0];
                if (pending_after_ack[~mark_desc.bank]) begin
                    older <= ~mark_desc.bank;
                end
            end
        end
    end

    assign page_ready = |pending;
    assign page_bank  = page_ready & sel;
    assign page_len   = page_ready ? len_q[sel] : '0;

endmodule

// File: rtl/capture_page_sequencer.sv
// rtl/capture_page_sequencer.sv - ping-pong capture page sequencer; CAPTURE_SAMPLE_CNT_EN enables the total_samples counter
module capture_page_sequencer
    import capture_pkg::*;
#(
    parameter int  SAMPLE_W   = 32,
    parameter int  PAGE_DEPTH = 16,
    parameter int  POST_W     = 16,
    localparam int PAGE_AW    = page_aw(PAGE_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                idle,
    input  logic                pre_trigger,
    input  logic                post_trigger,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic                trig_pulse,
    input  logic [POST_W-1:0]   post_count,
    output logic                buf_we,
    output logic [PAGE_AW:0]    buf_addr,
    output logic [SAMPLE_W-1:0] buf_wdata,
    output logic                page_ready,
    output logic                page_bank,
    output logic [PAGE_AW:0]    page_len,
    input  logic                page_ack,
    output logic                page_full,
    output logic                complete,
    output logic                overrun,
    output logic                trig_bank,
    output logic [PAGE_AW-1:0]  trig_offset,
    output logic [31:0]         total_samples
);

    state_t             state;
    state_t             state_next;
    logic [PAGE_AW-1:0] offset;
    logic               bank;
    logic               pre_q;
    logic               trig_seen;
    logic [POST_W-1:0]  remaining;
    logic [POST_W-1:0]  load_rem;

    logic               accept;
    logic               drop;
    logic               start;
    logic               flush_done;
    logic               close_full;
    logic               trig_load;
    logic               rem_dec;
    logic               done;
    logic               blocked;
    logic               ack_blocker;
    logic               mark_valid;
    page_desc_t         mark_desc;
    logic [1:0]         pending_after_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_FILL;
            end
            S_FILL: begin
                if (accept && done) begin
                    state_next = S_FLUSH;
                end else if (close_full && blocked) begin
                    state_next = S_STALL;
                end else if (idle) begin
                    state_next = S_IDLE;
                end
            end
            S_STALL: begin
                if (ack_blocker) state_next = S_FILL;
            end
            S_FLUSH: begin
                if (flush_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        accept     = 1'b0;
        drop       = 1'b0;
        start      = 1'b0;
        flush_done = 1'b0;
        case (state)
            S_IDLE:  start      = pre_trigger & ~pre_q;
            S_FILL:  accept     = sample_valid & (pre_trigger | post_trigger);
            S_STALL: drop       = sample_valid & (pre_trigger | post_trigger);
            S_FLUSH: flush_done = ~page_ready;
            default: ;
        endcase
    end

    // The trigger sample itself counts toward post_count, so the load already includes it.
    always_comb begin
        load_rem       = (post_count == '0) ? '0 : post_count - POST_W'(1);
        close_full     = accept & (offset == PAGE_AW'(PAGE_DEPTH - 1));
        trig_load      = accept & trig_pulse & pre_trigger & ~trig_seen;
        rem_dec        = accept & post_trigger & trig_seen & (remaining != '0);
        done           = trig_load ? (load_rem == '0) : (rem_dec & (remaining == POST_W'(1)));
        blocked        = pending_after_ack[~bank];
        ack_blocker    = page_ack & page_ready & (page_bank == bank);
        mark_valid     = close_full | (accept & done);
        mark_desc.bank = bank;
        mark_desc.len  = LEN_W'({1'b0, offset}) + LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            page_full   <= 1'b0;
            complete    <= 1'b0;
            overrun     <= 1'b0;
            trig_bank   <= 1'b0;
            trig_offset <= '0;
            offset      <= '0;
            bank        <= 1'b0;
            remaining   <= '0;
            trig_seen   <= 1'b0;
            pre_q       <= 1'b0;
        end else begin
            buf_we    <= accept;
            page_full <= close_full;
            complete  <= flush_done;
            pre_q     <= pre_trigger;
            if (accept) begin
                buf_addr  <= {bank, offset};
                buf_wdata <= sample_data;
            end
            if (start) begin
                offset    <= '0;
                bank      <= 1'b0;
                remaining <= '0;
                overrun   <= 1'b0;
                trig_seen <= 1'b0;
            end else begin
                if (accept) begin
                    offset <= offset + PAGE_AW'(1);
                    if (close_full) bank <= ~bank;
                end
                if (trig_load) begin
                    trig_seen   <= 1'b1;
                    trig_bank   <= bank;
                    trig_offset <= offset;
                    remaining   <= load_rem;
                end else if (rem_dec) begin
                    remaining <= remaining - POST_W'(1);
                end
                if (drop) overrun <= 1'b1;
            end
        end
    end

    page_bank_tracker #(
        .PAGE_AW (PAGE_AW)
    ) u_tracker (
        .clk               (clk),
        .reset             (reset),
        .mark_valid        (mark_valid),
        .mark_desc         (mark_desc),
        .page_ack          (page_ack),
        .page_ready        (page_ready),
        .page_bank         (page_bank),
        .page_len          (page_len),
        .pending_after_ack (pending_after_ack)
    );

`ifdef CAPTURE_SAMPLE_CNT_EN
    logic [31:0] sample_cnt;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            sample_cnt <= '0;
        end else if (accept) begin
            sample_cnt <= sample_cnt + 32'd1;
        end
    end

    assign total_samples = sample_cnt;
`else
    assign total_samples = '0;
`endif

endmodule

// File: tb/tb_capture_page_sequencer.sv
// tb/tb_capture_page_sequencer.sv - scoreboard bench for capture_page_sequencer
module tb_capture_page_sequencer;
    import capture_pkg::*;

    localparam int SAMPLE_W   = 32;
    localparam int PAGE_DEPTH = 16;
    localparam int POST_W     = 16;
    localparam int AW         = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                idle;
    logic                pre_trigger;
    logic                post_trigger;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic                trig_pulse;
    logic [POST_W-1:0]   post_count;
    logic                buf_we;
    logic [AW:0]         buf_addr;
    logic [SAMPLE_W-1:0] buf_wdata;
    logic                page_ready;
    logic                page_bank;
    logic [AW:0]         page_len;
    logic                page_ack;
    logic                page_full;
    logic                complete;
    logic                overrun;
    logic                trig_bank;
    logic [AW-1:0]       trig_offset;
    logic [31:0]         total_samples;

    always #5 clk = ~clk;

    capture_page_sequencer #(
        .SAMPLE_W   (SAMPLE_W),
        .PAGE_DEPTH (PAGE_DEPTH),
        .POST_W     (POST_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .idle          (idle),
        .pre_trigger   (pre_trigger),
        .post_trigger  (post_trigger),
        .sample_valid  (sample_valid),
        .sample_data   (sample_data),
        .trig_pulse    (trig_pulse),
        .post_count    (post_count),
        .buf_we        (buf_we),
        .buf_addr      (buf_addr),
        .buf_wdata     (buf_wdata),
        .page_ready    (page_ready),
        .page_bank     (page_bank),
        .page_len      (page_len),
        .page_ack      (page_ack),
        .page_full     (page_full),
        .complete      (complete),
        .overrun       (overrun),
        .trig_bank     (trig_bank),
        .trig_offset   (trig_offset),
        .total_samples (total_samples)
    );

    typedef struct {
        logic [AW:0]         addr;
        logic [SAMPLE_W-1:0] data;
        logic                full;
    } wr_t;

    typedef struct {
        logic        bank;
        logic [AW:0] len;
    } pg_t;

    wr_t         wr_q[$];
    pg_t         pg_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pf_cnt, cmp_cnt, we_cnt, ack_cnt, cyc_no, ack_cyc, cmp_cyc, we_before;
    int          ack_delay, rdy_cnt;
    logic        ack_en;
    logic        m_bank;
    logic [AW-1:0] m_off;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        wr_t  w;
        logic exp_we;
        logic exp_pf;
        cyc_no++;
        if (complete === 1'b1) begin
            cmp_cnt++;
            cmp_cyc = cyc_no;
        end
        if (page_full === 1'b1) pf_cnt++;
        exp_we = (wr_q.size() != 0);
        exp_pf = 1'b0;
        chk("buf_we", 64'(buf_we), 64'(exp_we));
        if (exp_we) begin
            w = wr_q.pop_front();
            if (buf_we === 1'b1) we_cnt++;
            chk("buf_addr", 64'(buf_addr), 64'(w.addr));
            chk("buf_wdata", 64'(buf_wdata), 64'(w.data));
            exp_pf = w.full;
        end else if (buf_we === 1'b1) begin
            we_cnt++;
        end
        chk("page_full", 64'(page_full), 64'(exp_pf));
    endtask

    task automatic cyc();
        pg_t p;
        page_ack = 1'b0;
        if (ack_en && page_ready === 1'b1) begin
            if (rdy_cnt >= ack_delay) begin
                if (pg_q.size() == 0) begin
                    chk("page_ready_unexpected", 64'(page_ready), 64'(0));
                end else begin
                    p = pg_q.pop_front();
                    chk("page_bank", 64'(page_bank), 64'(p.bank));
                    chk("page_len", 64'(page_len), 64'(p.len));
                end
                page_ack = 1'b1;
                ack_cnt++;
                ack_cyc = cyc_no;
                rdy_cnt = 0;
            end else begin
                rdy_cnt++;
            end
        end else begin
            rdy_cnt = 0;
        end
        @(posedge clk);
        @(negedge clk);
        observe();
    endtask

    task automatic send(input logic pre, input logic post, input logic trig,
                        input logic acc, input logic last);
        wr_t w;
        idle         = 1'b0;
        pre_trigger  = pre;
        post_trigger = post;
        sample_valid = 1'b1;
        trig_pulse   = trig;
        sample_data  = $urandom;
        if (acc) begin
            w.addr = {m_bank, m_off};
            w.data = sample_data;
            w.full = (m_off == 4'(PAGE_DEPTH - 1));
            wr_q.push_back(w);
            if (w.full || last) pg_q.push_back('{m_bank, {1'b0, m_off} + 5'd1});
            if (w.full) m_bank = ~m_bank;
            m_off = m_off + 4'd1;
        end
        cyc();
        sample_valid = 1'b0;
        trig_pulse   = 1'b0;
    endtask

    task automatic start_capture();
        idle         = 1'b0;
        pre_trigger  = 1'b1;
        post_trigger = 1'b0;
        sample_valid = 1'b0;
        m_bank       = 1'b0;
        m_off        = '0;
        pf_cnt       = 0;
        cmp_cnt      = 0;
        ack_cnt      = 0;
        cyc();
    endtask

    task automatic go_idle(input int n);
        idle         = 1'b1;
        pre_trigger  = 1'b0;
        post_trigger = 1'b0;
        sample_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic wait_complete();
        sample_valid = 1'b0;
        for (int i = 0; i < 60 && cmp_cnt == 0; i++) cyc();
    endtask

    initial begin
        reset = 1'b1; idle = 1'b1; pre_trigger = 1'b0; post_trigger = 1'b0;
        sample_valid = 1'b0; sample_data = '0; trig_pulse = 1'b0; post_count = '0;
        page_ack = 1'b0; ack_en = 1'b0; ack_delay = 0; rdy_cnt = 0;
        pf_cnt = 0; cmp_cnt = 0; we_cnt = 0; ack_cnt = 0; cyc_no = 0; ack_cyc = 0; cmp_cyc = 0;
        m_bank = 1'b0; m_off = '0;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_buf_we", 64'(buf_we), 64'(0));
        chk("rst_buf_addr", 64'(buf_addr), 64'(0));
        chk("rst_buf_wdata", 64'(buf_wdata), 64'(0));
        chk("rst_page_ready", 64'(page_ready), 64'(0));
        chk("rst_page_bank", 64'(page_bank), 64'(0));
        chk("rst_page_len", 64'(page_len), 64'(0));
        chk("rst_complete", 64'(complete), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        chk("rst_trig", 64'({trig_bank, trig_offset}), 64'(0));
        chk("rst_total", 64'(total_samples), 64'(0));
        chk("rst_state", 64'(dut.state), 64'(S_IDLE));
        reset = 1'b0;
        go_idle(2);

        // trigger at sample 10, four post samples, ack two cycles after ready
        post_count = 16'd4; ack_en = 1'b1; ack_delay = 2;
        start_capture();
        for (int i = 0; i < 9; i++) send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_complete();
        chk("t1_complete_seen", 64'(cmp_cnt), 64'(1));
        chk("t1_complete_after_ack", 64'(cmp_cyc > ack_cyc), 64'(1));
        go_idle(3);
        chk("t1_complete_once", 64'(cmp_cnt), 64'(1));
        chk("t1_pages", 64'(ack_cnt), 64'(1));
        chk("t1_trig_offset", 64'(trig_offset), 64'(9));
        chk("t1_trig_bank", 64'(trig_bank), 64'(0));
        chk("t1_no_page_full", 64'(pf_cnt), 64'(0));

        // 40 pre-trigger samples with immediate acks
        ack_delay = 0;
        start_capture();
        for (int i = 0; i < 40; i++) send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        go_idle(3);
        chk("t2_page_full_count", 64'(pf_cnt), 64'(2));
        chk("t2_pages", 64'(ack_cnt), 64'(2));
        chk("t2_ready_after_abort", 64'(page_ready), 64'(0));

        // acks withheld through two full pages, then five dropped samples
        ack_en = 1'b0;
        start_capture();
        for (int i = 0; i < 32; i++) send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_state_stall", 64'(dut.state), 64'(S_STALL));
        we_before = we_cnt;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_no_writes", 64'(we_cnt - we_before), 64'(0));
        chk("t3_overrun", 64'(overrun), 64'(1));
        ack_en = 1'b1;
        sample_valid = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        go_idle(3);
        chk("t3_pages", 64'(ack_cnt), 64'(2));
        chk("t3_ready_drained", 64'(page_ready), 64'(0));

        // post_count=6 with trigger at offset 10: close and flush together
        post_count = 16'd6;
        start_capture();
        for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_complete();
        go_idle(3);
        chk("t4_complete_once", 64'(cmp_cnt), 64'(1));
        chk("t4_page_full_once", 64'(pf_cnt), 64'(1));
        chk("t4_pages", 64'(ack_cnt), 64'(1));
        chk("t4_trig_offset", 64'(trig_offset), 64'(10));
        chk("t4_no_empty_page", 64'(page_ready), 64'(0));

        // reset with pages pending and overrun set
        ack_en = 1'b0;
        start_capture();
        for (int i = 0; i < 32; i++) send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_pre_ready", 64'(page_ready), 64'(1));
        chk("t5_pre_overrun", 64'(overrun), 64'(1));
        reset = 1'b1; idle = 1'b1; pre_trigger = 1'b0;
        cyc();
        chk("t5_ready", 64'(page_ready), 64'(0));
        chk("t5_overrun", 64'(overrun), 64'(0));
        chk("t5_complete", 64'(complete), 64'(0));
        chk("t5_state", 64'(dut.state), 64'(S_IDLE));
        pg_q.delete();
        reset = 1'b0;
        go_idle(2);

        // accepted-sample counter
        ack_en = 1'b1;
        start_capture();
        for (int i = 0; i < 37; i++) send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef CAPTURE_SAMPLE_CNT_EN
        chk("t6_total", 64'(total_samples), 64'(37));
`else
        chk("t6_total", 64'(total_samples), 64'(0));
`endif
        go_idle(3);
`ifdef CAPTURE_SAMPLE_CNT_EN
        chk("t6_total_hold", 64'(total_samples), 64'(37));
`else
        chk("t6_total_hold", 64'(total_samples), 64'(0));
`endif
        chk("t6_pages", 64'(ack_cnt), 64'(2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
